// File: rtl/noiseacq_pkg.sv
// Shared types and elaboration-time helpers for the noise-acquisition engine.
// NOISEACQ_DECIM_EN widens the output word to hold a boxcar sum.
package noiseacq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

`ifdef NOISEACQ_DECIM_EN
  localparam bit DECIM_EN = 1'b1;
`else
  localparam bit DECIM_EN = 1'b0;
`endif

  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

  // A sum of up to 2**dec_w samples needs dec_w extra bits.
  function automatic int out_w(input int data_w, input int dec_w);
    return DECIM_EN ? data_w + dec_w : data_w;
  endfunction

endpackage

// File: rtl/noiseacq_fifo.sv
// Single-clock FIFO with flush, registered read data and a dropped-write pulse.
// Pointers carry an extra wrap bit so full and empty fall out of a compare.
module noiseacq_fifo
  import noiseacq_pkg::*;
#(
  parameter int W     = 12,
  parameter int DEPTH = 4096
) (
  input  logic         clk_sys,
  input  logic         n_reset,
  input  logic         flush,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         rd_vld,
  output logic         full,
  output logic         empty,
  output logic         wr_drop
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [W-1:0] rd_data_q, rd_data_d;
  logic         rd_vld_q, rd_vld_d;
  logic         rd_ok, wr_ok;
  logic [W-1:0] mem [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first; a path that skips it would infer a latch.
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_data_d = rd_data_q;
    rd_vld_d  = 1'b0;
    // A read frees a slot in the same cycle, so a full FIFO still accepts a paired write.
    rd_ok     = rd_en && !empty && !flush;
    wr_ok     = wr_en && !flush && (!full || rd_ok);
    wr_drop   = wr_en && !flush && !wr_ok;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_ok) begin
        rd_ptr_d  = rd_ptr_q + PTR_ONE;
        rd_data_d = mem[rd_ptr_q[AW-1:0]];
        rd_vld_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge n_reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!n_reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_data_q <= rd_data_d;
      rd_vld_q  <= rd_vld_d;
    end
  end

  // NOTE: the storage array is not reset; pointers define validity and a reset would block RAM mapping.
  always_ff @(posedge clk_sys) begin
    if (wr_ok) mem[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  assign rd_data = rd_data_q;
  assign rd_vld  = rd_vld_q;

endmodule

// File: rtl/noiseacq_mc.sv
// Noise-acquisition engine: ADC clock divider, sample capture, word count and FIFO.
// Define NOISEACQ_DECIM_EN to add the n_decim port and boxcar decimation.
module noiseacq_mc
  import noiseacq_pkg::*;
#(
  parameter int  DATA_W = 12,
  parameter int  DIV_W  = 10,
  parameter int  CNT_W  = 12,
  parameter int  DEPTH  = 4096,
  parameter int  DEC_W  = 4,
  localparam int OUT_W  = out_w(DATA_W, DEC_W)
) (
  input  logic              clk_sys,
  input  logic              n_reset,
  input  logic              n_load,
  input  logic              n_en,
  input  logic [DIV_W-1:0]  n_divnum,
  input  logic [CNT_W-1:0]  n_acqnum,
`ifdef NOISEACQ_DECIM_EN
  input  logic [DEC_W-1:0]  n_decim,
`endif
  input  logic [DATA_W-1:0] n_adcdata,
  input  logic              n_rd_en,
  output logic              n_acqclk,
  output logic [OUT_W-1:0]  n_dataout,
  output logic              n_dataout_vld,
  output logic              n_empty,
  output logic              n_full,
  output logic              n_done,
  output logic              n_ovf
);

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  divnum_q, divnum_d, div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0]  acqnum_q, acqnum_d, word_cnt_q, word_cnt_d;
  logic              acqclk_q, acqclk_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              sample_vld_q, sample_vld_d;
  logic              ovf_q, ovf_d;
  logic              run_ok, wr_fire, last_word, fifo_drop;
  logic [OUT_W-1:0]  wr_word;
`ifdef NOISEACQ_DECIM_EN
  logic [DEC_W-1:0]  decim_q, decim_d, dec_cnt_q, dec_cnt_d;
  logic [OUT_W-1:0]  acc_q, acc_d;
`endif

  always_comb begin
    state_d      = state_q;
    divnum_d     = divnum_q;
    acqnum_d     = acqnum_q;
    div_cnt_d    = div_cnt_q;
    acqclk_d     = acqclk_q;
    word_cnt_d   = word_cnt_q;
    sample_d     = sample_q;
    sample_vld_d = 1'b0;
    ovf_d        = ovf_q | fifo_drop;
    run_ok       = (state_q == ST_RUN) && n_en && !n_load;
`ifdef NOISEACQ_DECIM_EN
    decim_d   = decim_q;
    dec_cnt_d = dec_cnt_q;
    acc_d     = acc_q;
    wr_word   = acc_q + OUT_W'(sample_q);
    wr_fire   = run_ok && sample_vld_q && (dec_cnt_q == decim_q);
    if (run_ok && sample_vld_q) begin
      if (dec_cnt_q == decim_q) begin
        acc_d     = '0;
        dec_cnt_d = '0;
      end else begin
        acc_d     = wr_word;
        dec_cnt_d = dec_cnt_q + DEC_W'(1);
      end
    end
`else
    wr_word = sample_q;
    wr_fire = run_ok && sample_vld_q;
`endif
    last_word = wr_fire &&
                (({1'b0, word_cnt_q} + (CNT_W + 1)'(1)) == {1'b0, acqnum_q});

    unique case (state_q)
      ST_IDLE: begin
        if (n_en) state_d = (acqnum_q == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (!n_en)          state_d = ST_IDLE;
        else if (last_word) state_d = ST_DONE;
        if (wr_fire) word_cnt_d = word_cnt_q + CNT_W'(1);
        if (div_cnt_q == divnum_q) begin
          div_cnt_d = '0;
          acqclk_d  = ~acqclk_q;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
        // Sample on the falling edge of the ADC clock.
        if (run_ok && acqclk_q && (div_cnt_q == divnum_q)) begin
          sample_d     = n_adcdata;
          sample_vld_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (!n_en) begin
          state_d    = ST_IDLE;
          word_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (n_load) begin
      state_d    = ST_IDLE;
      divnum_d   = n_divnum;
      acqnum_d   = n_acqnum;
      word_cnt_d = '0;
      ovf_d      = 1'b0;
`ifdef NOISEACQ_DECIM_EN
      decim_d    = n_decim;
`endif
    end

    // Outside RUN the ADC clock idles low and any in-flight sample or partial sum is discarded.
    if (state_d != ST_RUN) begin
      div_cnt_d    = '0;
      acqclk_d     = 1'b0;
      sample_vld_d = 1'b0;
`ifdef NOISEACQ_DECIM_EN
      dec_cnt_d    = '0;
      acc_d        = '0;
`endif
    end
  end

  always_ff @(posedge clk_sys or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= ST_IDLE;
      divnum_q     <= '0;
      acqnum_q     <= '0;
      div_cnt_q    <= '0;
      acqclk_q     <= 1'b0;
      word_cnt_q   <= '0;
      sample_q     <= '0;
      sample_vld_q <= 1'b0;
      ovf_q        <= 1'b0;
`ifdef NOISEACQ_DECIM_EN
      decim_q      <= '0;
      dec_cnt_q    <= '0;
      acc_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      divnum_q     <= divnum_d;
      acqnum_q     <= acqnum_d;
      div_cnt_q    <= div_cnt_d;
      acqclk_q     <= acqclk_d;
      word_cnt_q   <= word_cnt_d;
      sample_q     <= sample_d;
      sample_vld_q <= sample_vld_d;
      ovf_q        <= ovf_d;
`ifdef NOISEACQ_DECIM_EN
      decim_q      <= decim_d;
      dec_cnt_q    <= dec_cnt_d;
      acc_q        <= acc_d;
`endif
    end
  end

  noiseacq_fifo #(
    .W     (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_sys (clk_sys),
    .n_reset (n_reset),
    .flush   (n_load),
    .wr_en   (wr_fire),
    .wr_data (wr_word),
    .rd_en   (n_rd_en),
    .rd_data (n_dataout),
    .rd_vld  (n_dataout_vld),
    .full    (n_full),
    .empty   (n_empty),
    .wr_drop (fifo_drop)
  );

  assign n_acqclk = acqclk_q;
  assign n_done   = (state_q == ST_DONE);
  assign n_ovf    = ovf_q;

endmodule
